// File: rtl/tpu_isa_pkg.sv
// Shared ISA definitions for the TPU control path: opcodes, loader state
// encoding and loader error codes.
package tpu_isa_pkg;

  localparam logic [2:0] NO_OP       = 3'b000;
  localparam logic [2:0] LOAD_ADDR   = 3'b001;
  localparam logic [2:0] LOAD_WEIGHT = 3'b010;
  localparam logic [2:0] LOAD_INPUTS = 3'b011;
  localparam logic [2:0] COMPUTE     = 3'b100;
  localparam logic [2:0] STORE       = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } loader_state_t;

  // STORE is the highest defined opcode; 110 and 111 are reserved.
  function automatic logic is_legal_opcode(input logic [2:0] op);
    return op <= STORE;
  endfunction

endpackage

// File: rtl/instruction_loader_instr_mem.sv
// Instruction memory: one write port, one registered read port. A write and
// a read to the same address in the same cycle return the old contents.
module instr_mem #(
  parameter int DEPTH = 8,
  parameter int IW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [IW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [IW-1:0] rd_data_o
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rd_data_q;

  // Storage and read register; reset fills every entry with NO_OP (all zero).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_loader.sv
// Host-facing instruction loader: accepts instruction words, screens the
// opcode, fills the instruction memory and launches the control unit once a
// NO_OP terminator is loaded and the host asks to go.
module instruction_loader
  import tpu_isa_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_valid,
  input  logic [IW-1:0] host_data,
  output logic          host_ready,
  input  logic          go,
  input  logic          clear_err,
  input  logic          run_done,
  output logic          start,
  input  logic [AW-1:0] fetch_addr,
  output logic [IW-1:0] fetch_instr,
  output logic [AW:0]   word_count,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  loader_state_t state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   word_count_q;
  logic          start_q;
  logic [1:0]    err_code_q;

  logic xfer;
  logic legal;
  logic is_nop;
  logic mem_we;

  // Handshake and word classification; only legal words reach memory.
  always_comb begin
    legal  = is_legal_opcode(host_data[IW-1 -: 3]);
    is_nop = (host_data == '0);
    xfer   = host_valid && host_ready;
    mem_we = xfer && legal;
  end

  // Loader FSM with registered start pulse, write pointer, count and error code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= '0;
      word_count_q <= '0;
      start_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
            if (!legal) begin
              state_q    <= ST_ERROR;
              err_code_q <= ERR_ILLEGAL;
            end else begin
              wr_ptr_q     <= wr_ptr_q + PTR_ONE;
              word_count_q <= word_count_q + CNT_ONE;
              // Terminator check comes first: a NO_OP in the last slot still arms.
              if (is_nop) begin
                state_q <= ST_ARMED;
              end else if (word_count_q == CNT_LAST) begin
                state_q    <= ST_ERROR;
                err_code_q <= ERR_OVERFLOW;
              end
            end
          end
        end
        ST_ARMED: begin
          if (go) begin
            start_q <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_done) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
          end
        end
        ST_ERROR: begin
          if (clear_err) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            err_code_q   <= ERR_NONE;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign host_ready = (state_q == ST_LOAD) && !reset;
  assign err        = (state_q == ST_ERROR);
  assign start      = start_q;
  assign word_count = word_count_q;
  assign err_code   = err_code_q;

  instr_mem #(
    .DEPTH(DEPTH),
    .IW   (IW),
    .AW   (AW)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (mem_we),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(host_data),
    .rd_addr_i(fetch_addr),
    .rd_data_o(fetch_instr)
  );

endmodule
